// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types and decode helpers for the nibble-serial ALU sequencer.
package alu_nibble_sequencer_pkg;

    // ALU operation codes. Codes 9..15 are undefined and behave as a plain pass of B.
    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluAdc   = 4'd1,
        AluSub   = 4'd2,
        AluSbc   = 4'd3,
        AluAnd   = 4'd4,
        AluXor   = 4'd5,
        AluOr    = 4'd6,
        AluCp    = 4'd7,
        AluShift = 4'd8
    } alu_op_t;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } seq_state_t;

    // Function performed by the shared 4-bit core.
    typedef enum logic [2:0] {
        CoreAdd,
        CoreSub,
        CoreAnd,
        CoreXor,
        CoreOr,
        CorePass
    } core_fn_t;

    // Map an op code (possibly undefined) onto a core function.
    function automatic core_fn_t core_fn_of(logic [3:0] op);
        core_fn_t fn;
        case (op)
            AluAdd, AluAdc:        fn = CoreAdd;
            AluSub, AluSbc, AluCp: fn = CoreSub;
            AluAnd:                fn = CoreAnd;
            AluXor:                fn = CoreXor;
            AluOr:                 fn = CoreOr;
            default:               fn = CorePass;
        endcase
        return fn;
    endfunction

    // Only ADC and SBC feed the incoming carry into the low nibble.
    function automatic logic uses_cin(logic [3:0] op);
        return (op == AluAdc) || (op == AluSbc);
    endfunction

endpackage

// File: rtl/alu_nibble_core.sv
// 4-bit add/subtract/logic slice with carry (or borrow) in and out and signed overflow.
module alu_nibble_core
    import alu_nibble_sequencer_pkg::*;
(
    input  core_fn_t   fn_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] y_o,
    output logic       cout_o,
    output logic       ovf_o
);

    logic [4:0] sum_add;
    logic [4:0] sum_sub;

    // Subtraction borrow shows up as bit 4 of the 5-bit wrapped difference.
    always_comb begin
        sum_add = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
        sum_sub = {1'b0, a_i} - {1'b0, b_i} - {4'd0, cin_i};
        y_o     = b_i;
        cout_o  = 1'b0;
        ovf_o   = 1'b0;
        case (fn_i)
            CoreAdd: begin
                y_o    = sum_add[3:0];
                cout_o = sum_add[4];
                ovf_o  = (a_i[3] == b_i[3]) && (sum_add[3] != a_i[3]);
            end
            CoreSub: begin
                y_o    = sum_sub[3:0];
                cout_o = sum_sub[4];
                ovf_o  = (a_i[3] != b_i[3]) && (sum_sub[3] != a_i[3]);
            end
            CoreAnd: y_o = a_i & b_i;
            CoreXor: y_o = a_i ^ b_i;
            CoreOr:  y_o = a_i | b_i;
            default: y_o = b_i;
        endcase
    end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial ALU: captures operands on start, computes the low nibble, then the high
// nibble through a single shared 4-bit core, and registers result and flags.
module alu_nibble_sequencer
    import alu_nibble_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [7:0] acc,
    input  logic [3:0] shift_high,
    input  logic [3:0] shift_low,
    input  logic       shift_db0,
    input  logic       shift_db7,
    input  logic       shift_left,
    input  logic       shift_right,
    input  logic       cf_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       cf,
    output logic       hf,
    output logic       zf,
    output logic       sf,
    output logic       pvf,
    output logic       nf
);

    seq_state_t state_q;
    logic [3:0] op_q;
    logic [7:0] acc_q;
    logic [7:0] b_q;
    logic       db0_q, db7_q, shl_q, shr_q, cf_in_q;
    logic [3:0] low_q;
    logic       hc_q;
    logic       busy_q, done_q;
    logic [7:0] result_q;
    logic       cf_q, hf_q, zf_q, sf_q, pvf_q, nf_q;

    core_fn_t   core_fn;
    logic [3:0] core_a, core_b, core_y;
    logic       core_cin, core_cout, core_ovf;
    logic       hi_sel;

    logic [7:0] full_y;
    logic [7:0] result_d;
    logic       cf_d, hf_d, zf_d, sf_d, pvf_d, nf_d;

    // Steer the captured operand nibbles into the shared core; HIGH chains the half carry.
    always_comb begin
        hi_sel   = (state_q == StHigh);
        core_fn  = core_fn_of(op_q);
        core_a   = hi_sel ? acc_q[7:4] : acc_q[3:0];
        core_b   = hi_sel ? b_q[7:4] : b_q[3:0];
        core_cin = hi_sel ? hc_q : (uses_cin(op_q) ? cf_in_q : 1'b0);
    end

    alu_nibble_core u_core (
        .fn_i   (core_fn),
        .a_i    (core_a),
        .b_i    (core_b),
        .cin_i  (core_cin),
        .y_o    (core_y),
        .cout_o (core_cout),
        .ovf_o  (core_ovf)
    );

    // Full-byte result and flags, valid during HIGH and loaded on the HIGH->DONE edge.
    always_comb begin
        full_y   = {core_y, low_q};
        result_d = full_y;
        cf_d     = 1'b0;
        hf_d     = 1'b0;
        zf_d     = (full_y == 8'h00);
        sf_d     = full_y[7];
        pvf_d    = ~^full_y;
        nf_d     = 1'b0;
        case (op_q)
            AluAdd, AluAdc: begin
                cf_d  = core_cout;
                hf_d  = hc_q;
                pvf_d = core_ovf;
            end
            AluSub, AluSbc: begin
                cf_d  = core_cout;
                hf_d  = hc_q;
                pvf_d = core_ovf;
                nf_d  = 1'b1;
            end
            AluCp: begin
                // Compare: flags from the difference, result byte untouched.
                result_d = result_q;
                cf_d     = core_cout;
                hf_d     = hc_q;
                pvf_d    = core_ovf;
                nf_d     = 1'b1;
            end
            AluAnd:        hf_d = 1'b1;
            AluXor, AluOr: hf_d = 1'b0;
            AluShift:      cf_d = shl_q ? db7_q : (shr_q ? db0_q : cf_in_q);
            default:       cf_d = cf_in_q;
        endcase
    end

    // Sequencer FSM with operand capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= 4'd0;
            acc_q    <= 8'h00;
            b_q      <= 8'h00;
            db0_q    <= 1'b0;
            db7_q    <= 1'b0;
            shl_q    <= 1'b0;
            shr_q    <= 1'b0;
            cf_in_q  <= 1'b0;
            low_q    <= 4'd0;
            hc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
            cf_q     <= 1'b0;
            hf_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            pvf_q    <= 1'b0;
            nf_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= op;
                        acc_q   <= acc;
                        b_q     <= {shift_high, shift_low};
                        db0_q   <= shift_db0;
                        db7_q   <= shift_db7;
                        shl_q   <= shift_left;
                        shr_q   <= shift_right;
                        cf_in_q <= cf_in;
                        busy_q  <= 1'b1;
                        state_q <= StLow;
                    end
                end
                StLow: begin
                    low_q   <= core_y;
                    hc_q    <= core_cout;
                    state_q <= StHigh;
                end
                StHigh: begin
                    result_q <= result_d;
                    cf_q     <= cf_d;
                    hf_q     <= hf_d;
                    zf_q     <= zf_d;
                    sf_q     <= sf_d;
                    pvf_q    <= pvf_d;
                    nf_q     <= nf_d;
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cf     = cf_q;
    assign hf     = hf_q;
    assign zf     = zf_q;
    assign sf     = sf_q;
    assign pvf    = pvf_q;
    assign nf     = nf_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for the nibble-serial ALU sequencer.
module tb_alu_nibble_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] acc = 8'h00;
    logic [3:0] shift_high = 4'd0;
    logic [3:0] shift_low = 4'd0;
    logic       shift_db0 = 1'b0;
    logic       shift_db7 = 1'b0;
    logic       shift_left = 1'b0;
    logic       shift_right = 1'b0;
    logic       cf_in = 1'b0;
    logic       busy, done;
    logic [7:0] result;
    logic       cf, hf, zf, sf, pvf, nf;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_result = 8'h00;

    always #5 clk = ~clk;

    alu_nibble_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .acc         (acc),
        .shift_high  (shift_high),
        .shift_low   (shift_low),
        .shift_db0   (shift_db0),
        .shift_db7   (shift_db7),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .cf_in       (cf_in),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .cf          (cf),
        .hf          (hf),
        .zf          (zf),
        .sf          (sf),
        .pvf         (pvf),
        .nf          (nf)
    );

    // Reference: returns {result, cf, hf, zf, sf, pvf, nf} from byte-level arithmetic.
    function automatic logic [13:0] model(logic [3:0] o, logic [7:0] a, logic [7:0] b,
                                          logic cin, logic sl, logic sr, logic d0, logic d7,
                                          logic [7:0] prev);
        int s, sa, sb, sv, c;
        logic [7:0] v, r;
        logic fc, fh, fp, fn;
        fc = 1'b0; fh = 1'b0; fp = 1'b0; fn = 1'b0;
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        v = b;
        r = b;
        case (o)
            4'd0, 4'd1: begin
                c  = (o == 4'd1) ? int'(cin) : 0;
                s  = int'(a) + int'(b) + c;
                v  = 8'(s);
                fc = (s > 255);
                fh = (int'(a & 8'h0F) + int'(b & 8'h0F) + c) > 15;
                sv = sa + sb + c;
                fp = (sv > 127) || (sv < -128);
                r  = v;
            end
            4'd2, 4'd3, 4'd7: begin
                c  = (o == 4'd3) ? int'(cin) : 0;
                s  = int'(a) - int'(b) - c;
                v  = 8'(s);
                fc = (s < 0);
                fh = (int'(a & 8'h0F) - int'(b & 8'h0F) - c) < 0;
                sv = sa - sb - c;
                fp = (sv > 127) || (sv < -128);
                fn = 1'b1;
                r  = (o == 4'd7) ? prev : v;
            end
            4'd4: begin v = a & b; fh = 1'b1; fp = ~^v; r = v; end
            4'd5: begin v = a ^ b; fp = ~^v; r = v; end
            4'd6: begin v = a | b; fp = ~^v; r = v; end
            4'd8: begin
                v = b; r = b; fp = ~^v;
                fc = sl ? d7 : (sr ? d0 : cin);
            end
            default: begin v = b; r = b; fp = ~^v; fc = cin; end
        endcase
        return {r, fc, fh, (v == 8'h00), v[7], fp, fn};
    endfunction

    // One operation with cycle-accurate busy/done checks; inputs are scrambled after capture.
    task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sl, input logic sr, input logic d0,
                          input logic d7, input logic restart, input string name);
        logic [13:0] e;
        logic eb, ed;
        e = model(o, a, b, cin, sl, sr, d0, d7, exp_result);
        @(negedge clk);
        op = o; acc = a; {shift_high, shift_low} = b; cf_in = cin;
        shift_left = sl; shift_right = sr; shift_db0 = d0; shift_db7 = d7;
        start = 1'b1;
        for (int ph = 1; ph <= 4; ph++) begin
            @(negedge clk);
            start = (ph <= 2) ? restart : 1'b0;
            if (ph <= 3) begin
                op = 4'($urandom); acc = 8'($urandom);
                {shift_high, shift_low} = 8'($urandom);
                {cf_in, shift_left, shift_right, shift_db0, shift_db7} = 5'($urandom);
            end
            eb = (ph <= 3);
            ed = (ph == 3);
            n_checks++;
            if (busy !== eb) begin
                n_fail++;
                $display("FAIL %s busy phase %0d: got %b expected %b", name, ph, busy, eb);
            end
            n_checks++;
            if (done !== ed) begin
                n_fail++;
                $display("FAIL %s done phase %0d: got %b expected %b", name, ph, done, ed);
            end
            if (ph >= 3) begin
                n_checks++;
                if (result !== e[13:6]) begin
                    n_fail++;
                    $display("FAIL %s result phase %0d: got %h expected %h", name, ph,
                             result, e[13:6]);
                end
                n_checks++;
                if ({cf, hf, zf, sf, pvf, nf} !== e[5:0]) begin
                    n_fail++;
                    $display("FAIL %s flags(c h z s pv n) phase %0d: got %b expected %b",
                             name, ph, {cf, hf, zf, sf, pvf, nf}, e[5:0]);
                end
            end
        end
        exp_result = e[13:6];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset busy/done: got %b expected 00", {busy, done});
        end
        n_checks++;
        if ({result, cf, hf, zf, sf, pvf, nf} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset result/flags: got %h expected 0",
                     {result, cf, hf, zf, sf, pvf, nf});
        end
        reset = 1'b0;
        exp_result = 8'h00;
    endtask

    task automatic test_directed();
        run_op(4'd0, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "add_halfcarry");
        run_op(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "add_overflow");
        run_op(4'd2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sub_borrow");
        run_op(4'd8, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "shift_left");
        run_op(4'd8, 8'h55, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "shift_right");
        run_op(4'd7, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cp_equal");
        n_checks++;
        if (result !== 8'h3C) begin
            n_fail++;
            $display("FAIL cp_keeps_result: got %h expected 3c", result);
        end
        run_op(4'd1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "adc_wrap");
        run_op(4'd3, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sbc_overflow");
        run_op(4'd4, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "and_zero");
        run_op(4'd12, 8'h12, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "undefined_op");
    endtask

    task automatic test_ignore_start();
        run_op(4'd5, 8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "start_while_busy");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL no_queued_op cycle %0d: got %b expected 00", i, {busy, done});
            end
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        op = 4'd6; acc = 8'h81; {shift_high, shift_low} = 8'h42; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort busy/done: got %b expected 00", {busy, done});
        end
        n_checks++;
        if ({result, cf, hf, zf, sf, pvf, nf} !== 14'd0) begin
            n_fail++;
            $display("FAIL abort result/flags: got %h expected 0",
                     {result, cf, hf, zf, sf, pvf, nf});
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_over_start busy: got %b expected 0", busy);
        end
        reset = 1'b0;
        start = 1'b0;
        exp_result = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done cycle %0d: got %b expected 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) == 0), "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(4'd8, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_load");
        run_op(4'd7, 8'h05, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_cp");
        run_op(4'd2, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_sub");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
